// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
// Later transmitter and flow-control blocks can reuse them.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rxState_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // The start bit is re-checked this many counts after its falling edge.
   function automatic int halfBit(input int clksPerBit);
      return (clksPerBit - 1) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Consumer-side bundle of the receiver: the held frame and its flags, plus ready.
// The master modport is the receiver side and the slave modport is the consumer side.
interface uart_rx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic                 rxDv;
   logic [DATA_BITS-1:0] rxByte;
   logic                 parityErr;
   logic                 frameErr;
   logic                 rxBreak;
   logic                 overrun;
   logic                 rxReady;

   modport master (
      output rxDv, rxByte, parityErr, frameErr, rxBreak, overrun,
      input  rxReady
   );

   modport slave (
      input  rxDv, rxByte, parityErr, frameErr, rxBreak, overrun,
      output rxReady
   );
endinterface

// File: rtl/uart_rx_frame_sync_2ff.sv
// Generic two-flop synchroniser with a selectable reset value.
// It brings asynchronous inputs into the clk_i domain.
module sync_2ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver with a configurable frame format and per-frame error flags.
// Completed frames are held in a ready/valid register, and overrun is reported.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5209,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = PARITY_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   input  logic                 i_Rx_Ready,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2((DATA_BITS > 2) ? DATA_BITS : 2);
   localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(halfBit(CLKS_PER_BIT));
   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

   logic rx;

   sync_2ff #(.RESET_VAL(1'b1)) uRxSync (
      .clk_i (i_Clock),
      .rst_i (i_Reset),
      .d_i   (i_Rx_Serial),
      .q_o   (rx)
   );

   rxState_e             state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 parBit_q;
   logic                 stopErr_q;
   logic                 rxDv_q;
   logic [DATA_BITS-1:0] rxByte_q;
   logic                 parityErr_q;
   logic                 frameErr_q;
   logic                 break_q;
   logic                 overrun_q;

   logic bitTick;
   logic frameDone;
   logic transfer;
   logic frameErr_d;
   logic parityErr_d;
   logic break_d;

   // The flags are evaluated at the final stop sample, so that sample is folded in directly.
   always_comb begin
      bitTick     = (cnt_q == CNT_LAST);
      frameDone   = (state_q == STOP) && bitTick && (idx_q == IDX_STOP_LAST);
      transfer    = rxDv_q & i_Rx_Ready;
      frameErr_d  = stopErr_q | ~rx;
      parityErr_d = 1'b0;
      if (PARITY_MODE == PARITY_ODD) begin
         parityErr_d = ~(^data_q ^ parBit_q);
      end else if (PARITY_MODE == PARITY_EVEN) begin
         parityErr_d = ^data_q ^ parBit_q;
      end
      break_d = (data_q == '0) && ((PARITY_MODE == PARITY_NONE) || !parBit_q) && frameErr_d;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         data_q      <= '0;
         parBit_q    <= 1'b0;
         stopErr_q   <= 1'b0;
         rxDv_q      <= 1'b0;
         rxByte_q    <= '0;
         parityErr_q <= 1'b0;
         frameErr_q  <= 1'b0;
         break_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q     <= '0;
               idx_q     <= '0;
               stopErr_q <= 1'b0;
               if (!rx) state_q <= START;
            end
            START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q   <= '0;
                  state_q <= rx ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (bitTick) begin
                  cnt_q         <= '0;
                  data_q[idx_q] <= rx;
                  if (idx_q == IDX_DATA_LAST) begin
                     idx_q   <= '0;
                     state_q <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            PARITY: begin
               if (bitTick) begin
                  cnt_q    <= '0;
                  parBit_q <= rx;
                  state_q  <= STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               if (bitTick) begin
                  cnt_q <= '0;
                  if (!rx) stopErr_q <= 1'b1;
                  if (idx_q == IDX_STOP_LAST) begin
                     idx_q   <= '0;
                     state_q <= rx ? IDLE : WAIT_HIGH;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WAIT_HIGH: begin
               if (rx) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         // A frame may replace the held one only when that one is leaving on this same edge.
         if (frameDone) begin
            if (!rxDv_q || transfer) begin
               rxDv_q      <= 1'b1;
               rxByte_q    <= data_q;
               parityErr_q <= parityErr_d;
               frameErr_q  <= frameErr_d;
               break_q     <= break_d;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (transfer) begin
            rxDv_q <= 1'b0;
         end
      end
   end

   assign o_Rx_DV      = rxDv_q;
   assign o_Rx_Byte    = rxByte_q;
   assign o_Parity_Err = parityErr_q;
   assign o_Frame_Err  = frameErr_q;
   assign o_Break      = break_q;
   assign o_Overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for three receiver configurations: 8N1, 7E1 and 8N2, each at 16 clocks per bit.
// Frames are generated as line levels, and expected results are derived from those levels.
module tb_uart_rx_frame;

   localparam int CPB = 16;
   localparam int H   = (CPB - 1) / 2;

   typedef bit bitQ_t[$];

   int dbits[3] = '{8, 7, 8};
   int pmode[3] = '{0, 2, 0};
   int sbits[3] = '{1, 1, 2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst[3];
   logic serial[3];
   logic ready[3];
   bit   holdReady[3];

   logic       dv[3];
   logic [7:0] rxb[3];
   logic       perr[3];
   logic       ferr[3];
   logic       brk[3];
   logic       ovr[3];

   uart_rx_frame_if #(.DATA_BITS(8)) if0 ();
   uart_rx_frame_if #(.DATA_BITS(7)) if1 ();
   uart_rx_frame_if #(.DATA_BITS(8)) if2 ();

   assign if0.rxReady = ready[0];
   assign if1.rxReady = ready[1];
   assign if2.rxReady = ready[2];

   assign dv[0] = if0.rxDv;  assign rxb[0] = if0.rxByte;         assign perr[0] = if0.parityErr;
   assign dv[1] = if1.rxDv;  assign rxb[1] = {1'b0, if1.rxByte}; assign perr[1] = if1.parityErr;
   assign dv[2] = if2.rxDv;  assign rxb[2] = if2.rxByte;         assign perr[2] = if2.parityErr;
   assign ferr[0] = if0.frameErr; assign brk[0] = if0.rxBreak; assign ovr[0] = if0.overrun;
   assign ferr[1] = if1.frameErr; assign brk[1] = if1.rxBreak; assign ovr[1] = if1.overrun;
   assign ferr[2] = if2.frameErr; assign brk[2] = if2.rxBreak; assign ovr[2] = if2.overrun;

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut8n1 (
      .i_Clock(clk), .i_Reset(rst[0]), .i_Rx_Serial(serial[0]), .i_Rx_Ready(if0.rxReady),
      .o_Rx_DV(if0.rxDv), .o_Rx_Byte(if0.rxByte), .o_Parity_Err(if0.parityErr),
      .o_Frame_Err(if0.frameErr), .o_Break(if0.rxBreak), .o_Overrun(if0.overrun));

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) dut7e1 (
      .i_Clock(clk), .i_Reset(rst[1]), .i_Rx_Serial(serial[1]), .i_Rx_Ready(if1.rxReady),
      .o_Rx_DV(if1.rxDv), .o_Rx_Byte(if1.rxByte), .o_Parity_Err(if1.parityErr),
      .o_Frame_Err(if1.frameErr), .o_Break(if1.rxBreak), .o_Overrun(if1.overrun));

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut8n2 (
      .i_Clock(clk), .i_Reset(rst[2]), .i_Rx_Serial(serial[2]), .i_Rx_Ready(if2.rxReady),
      .o_Rx_DV(if2.rxDv), .o_Rx_Byte(if2.rxByte), .o_Parity_Err(if2.parityErr),
      .o_Frame_Err(if2.frameErr), .o_Break(if2.rxBreak), .o_Overrun(if2.overrun));

   int checks = 0;
   int passes = 0;

   int         dvEdge, ovrEdge, ovrCount, riseCount;
   logic [7:0] capByte;
   logic       capPerr, capFerr, capBrk;

   // Counts every comparison and reports any mismatch on a single line.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Builds the line levels for one frame: start, data LSB first, optional parity, then stop bits.
   function automatic bitQ_t makeFrame(input int d, input logic [8:0] data, input bit badPar, input int stopZeroMask);
      bitQ_t lv;
      bit p = 1'b0;
      lv.push_back(1'b0);
      for (int i = 0; i < dbits[d]; i++) begin
         lv.push_back(data[i]);
         p = p ^ data[i];
      end
      if (pmode[d] != 0) lv.push_back(((pmode[d] == 1) ? ~p : p) ^ badPar);
      for (int i = 0; i < sbits[d]; i++) lv.push_back(((stopZeroMask >> i) & 1) == 0);
      return lv;
   endfunction

   // Reference model: decodes the line levels and predicts the flags and the completion edge.
   task automatic modelFrame(input int d, input bitQ_t lv, output logic [7:0] eData, output bit ePar,
                             output bit eFrm, output bit eBrk, output int eEdge);
      int  idx  = 1;
      int  ones = 0;
      bit  p    = 1'b0;
      eData = 8'h00;
      for (int i = 0; i < dbits[d]; i++) begin
         eData[i] = lv[idx];
         ones += int'(lv[idx]);
         idx++;
      end
      ePar = 1'b0;
      if (pmode[d] != 0) begin
         p = lv[idx];
         idx++;
         ePar = (pmode[d] == 1) ? (((ones + int'(p)) % 2) == 0) : (((ones + int'(p)) % 2) == 1);
      end
      eFrm = 1'b0;
      for (int i = 0; i < sbits[d]; i++) begin
         if (lv[idx] == 1'b0) eFrm = 1'b1;
         idx++;
      end
      eBrk  = (ones == 0) && (pmode[d] == 0 || p == 1'b0) && eFrm;
      eEdge = 3 + H + (dbits[d] + ((pmode[d] != 0) ? 1 : 0) + sbits[d]) * CPB;
   endtask

   // Drives one clock of line level and ready, then samples the outputs 1 ns after the edge.
   task automatic applyStimulus(input int d, input logic lineVal, input logic rdy);
      serial[d] = lineVal;
      ready[d]  = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic sendLevels(input int d, input bitQ_t lv, input int trail, input int readyEdge);
      int   bitCycles = lv.size() * CPB;
      logic prev      = dv[d];
      dvEdge = -1; ovrEdge = -1; ovrCount = 0; riseCount = 0;
      for (int s = 0; s < bitCycles + trail; s++) begin
         applyStimulus(d, (s < bitCycles) ? lv[s / CPB] : 1'b1, holdReady[d] || (s == readyEdge));
         if (!prev && dv[d]) begin
            riseCount++;
            if (dvEdge < 0) begin
               dvEdge  = s;
               capByte = rxb[d]; capPerr = perr[d]; capFerr = ferr[d]; capBrk = brk[d];
            end
         end
         if (ovr[d]) begin
            ovrCount++;
            ovrEdge = s;
         end
         prev = dv[d];
      end
      ready[d] = holdReady[d];
   endtask

   task automatic runFrame(input int d, input bitQ_t lv, input string tag);
      logic [7:0] eData;
      bit         ePar, eFrm, eBrk;
      int         eEdge;
      modelFrame(d, lv, eData, ePar, eFrm, eBrk, eEdge);
      sendLevels(d, lv, 2 * CPB, -1);
      checkOutput({tag, "_dvEdge"}, dvEdge, eEdge);
      checkOutput({tag, "_byte"}, capByte, eData);
      checkOutput({tag, "_parErr"}, capPerr, ePar);
      checkOutput({tag, "_frmErr"}, capFerr, eFrm);
      checkOutput({tag, "_break"}, capBrk, eBrk);
      checkOutput({tag, "_ovr"}, ovrCount, 0);
   endtask

   task automatic acceptHeld(input int d, input string tag);
      checkOutput({tag, "_dvHeld"}, dv[d], 1'b1);
      applyStimulus(d, 1'b1, 1'b1);
      ready[d] = holdReady[d];
      checkOutput({tag, "_dvFall"}, dv[d], 1'b0);
   endtask

   initial begin
      bitQ_t lv;
      int    highCnt;
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; serial[d] = 1'b1; ready[d] = 1'b0; holdReady[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      for (int d = 0; d < 3; d++) begin
         checkOutput("rstDv", dv[d], 1'b0);
         checkOutput("rstOutputs", {rxb[d], perr[d], ferr[d], brk[d], ovr[d]}, 12'h000);
      end

      // 8N1 0xA5 held until accepted.
      runFrame(0, makeFrame(0, 9'h0A5, 1'b0, 0), "a5");
      repeat (20) applyStimulus(0, 1'b1, 1'b0);
      checkOutput("a5_stillHeld", {dv[0], rxb[0]}, {1'b1, 8'hA5});
      acceptHeld(0, "a5");

      // 7E1 parity good, then parity bad.
      runFrame(1, makeFrame(1, 9'h041, 1'b0, 0), "e7good");
      acceptHeld(1, "e7good");
      runFrame(1, makeFrame(1, 9'h041, 1'b1, 0), "e7bad");
      acceptHeld(1, "e7bad");

      // Low stop bit, then a 30-bit break.
      runFrame(0, makeFrame(0, 9'h03C, 1'b0, 1), "frm");
      acceptHeld(0, "frm");
      lv = {};
      repeat (30) lv.push_back(1'b0);
      sendLevels(0, lv, 4 * CPB, -1);
      checkOutput("brk_edge", dvEdge, 3 + H + 9 * CPB);
      checkOutput("brk_flags", {capByte, capBrk, capFerr, capPerr}, {8'h00, 1'b1, 1'b1, 1'b0});
      checkOutput("brk_rises", riseCount, 1);
      acceptHeld(0, "brk");

      // Short glitch must be rejected.
      highCnt = 0;
      repeat (4) applyStimulus(0, 1'b0, 1'b0);
      repeat (3 * CPB) begin
         applyStimulus(0, 1'b1, 1'b0);
         if (dv[0]) highCnt++;
      end
      checkOutput("glitch_noDv", highCnt, 0);
      runFrame(0, makeFrame(0, 9'h055, 1'b0, 0), "g55");
      acceptHeld(0, "g55");

      // Back-to-back frames: overrun when not ready, replacement when accepted on the completion edge.
      sendLevels(0, makeFrame(0, 9'h011, 1'b0, 0), 0, -1);
      checkOutput("ovr_first", capByte, 8'h11);
      sendLevels(0, makeFrame(0, 9'h022, 1'b0, 0), 2 * CPB, -1);
      checkOutput("ovr_count", ovrCount, 1);
      checkOutput("ovr_edge", ovrEdge, 3 + H + 9 * CPB);
      checkOutput("ovr_keep", {dv[0], rxb[0]}, {1'b1, 8'h11});
      acceptHeld(0, "ovr");
      sendLevels(0, makeFrame(0, 9'h011, 1'b0, 0), 0, -1);
      sendLevels(0, makeFrame(0, 9'h022, 1'b0, 0), 2 * CPB, 3 + H + 9 * CPB);
      checkOutput("swap_ovr", ovrCount, 0);
      checkOutput("swap_load", {dv[0], rxb[0]}, {1'b1, 8'h22});
      acceptHeld(0, "swap");

      // 8N2: hold a frame, then reset during data bit 3 of the next one.
      runFrame(2, makeFrame(2, 9'({$urandom} & 8'hFF), 1'b0, 0), "n2hold");
      lv = makeFrame(2, 9'h0C3, 1'b0, 0);
      for (int s = 0; s < 4 * CPB + CPB / 2; s++) applyStimulus(2, lv[s / CPB], 1'b0);
      rst[2] = 1'b1;
      applyStimulus(2, 1'b1, 1'b0);
      rst[2] = 1'b0;
      checkOutput("rstMid_outputs", {dv[2], rxb[2], perr[2], ferr[2], brk[2], ovr[2]}, 13'h0000);
      highCnt = 0;
      repeat (3 * CPB) begin
         applyStimulus(2, 1'b1, 1'b0);
         if (dv[2]) highCnt++;
      end
      checkOutput("rstMid_noDv", highCnt, 0);
      runFrame(2, makeFrame(2, 9'h0F0, 1'b0, 0), "n2f0");
      acceptHeld(2, "n2f0");

      // Randomized frames across all three formats.
      for (int n = 0; n < 45; n++) begin
         int         d;
         logic [8:0] data;
         bit         badPar;
         int         stopMask;
         d        = $urandom_range(0, 2);
         data     = ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom_range(0, 255));
         if (dbits[d] == 7) data[7] = 1'b0;
         badPar   = (pmode[d] != 0) && ($urandom_range(0, 3) == 0);
         stopMask = ($urandom_range(0, 4) == 0) ? $urandom_range(1, (1 << sbits[d]) - 1) : 0;
         holdReady[d] = bit'($urandom_range(0, 1));
         runFrame(d, makeFrame(d, data, badPar, stopMask), $sformatf("rnd%0d", n));
         if (holdReady[d]) checkOutput($sformatf("rnd%0d_autoAccept", n), dv[d], 1'b0);
         else acceptHeld(d, $sformatf("rnd%0d", n));
         holdReady[d] = 1'b0;
         ready[d]     = 1'b0;
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Next-generation UART receiver with configurable frame format: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits.
- Adds per-frame error flags (parity, framing, break), a ready/valid output holding register and overrun reporting.
- Sits between the board serial pin and the command decoder; drop-in for the fixed 8N1 receiver when the format or flow control differs.

Parameters:
- CLKS_PER_BIT, 5209, clock cycles per serial bit (≥ 4); half-bit point H = (CLKS_PER_BIT-1)/2, integer division.
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Rx_Serial  in  1  asynchronous serial line, idle high
- i_Rx_Ready  in  1  consumer accepts held frame
- o_Rx_DV  out  1  held frame valid; level held until accepted
- o_Rx_Byte  out  DATA_BITS  received data
- o_Parity_Err  out  1  held frame had bad parity; always 0 when PARITY_MODE = 0
- o_Frame_Err  out  1  held frame had a low stop bit
- o_Break  out  1  held frame was a break condition
- o_Overrun  out  1  one-cycle pulse: completed frame dropped

Behaviour:
- Reset:
  - One clock: i_Reset sampled high at a rising edge of i_Clock; reset is synchronous and active-high.
  - All outputs go to 0; both synchroniser flops go to 1; state goes to IDLE; counters go to 0.
  - Reset mid-frame abandons the frame and clears the holding register.
- Input synchronisation: two-flop synchroniser; all logic below uses the second flop, "rx". Latency is 2 cycles.
- State machine:
  - IDLE: counter = 0, bit index = 0. If rx = 0, go to START.
  - START: count up to H. At count = H: if rx = 0, clear counter and go to DATA; else go to IDLE (glitch rejected, no outputs change).
  - DATA: count 0..CLKS_PER_BIT-1. At the terminal count, sample rx into data[bit index] and clear the counter. After bit DATA_BITS-1, go to PARITY if PARITY_MODE ≠ 0, else go to STOP.
  - PARITY: one bit time; sample at the terminal count.
    - Odd mode: error if XOR(data, p) = 0.
    - Even mode: error if XOR(data, p) = 1.
  - STOP: STOP_BITS bit times; sample each at its terminal count. Any stop sample = 0 sets the frame error.
  - After the last stop sample, the frame completes. Go to IDLE if the last stop sample = 1; else go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx = 1, then go to IDLE. This prevents re-triggering during a held-low line.
- Break: data all 0, parity sample 0 (if present) and frame error set. Sets o_Break together with o_Frame_Err; o_Rx_Byte = 0.
- Holding register (data plus three flags) and handshake:
  - Frame complete with o_Rx_DV = 0: load the register; o_Rx_DV = 1 from the next cycle.
  - Transfer happens on a clock edge with o_Rx_DV & i_Rx_Ready. o_Rx_DV falls next cycle unless a frame completes on that same edge.
  - Frame completes on the same edge as a transfer: load the new frame; o_Rx_DV stays 1; no overrun.
  - Frame completes while o_Rx_DV = 1 and i_Rx_Ready = 0: drop the new frame, keep the held data, pulse o_Overrun for 1 cycle.
  - Outputs are stable while o_Rx_DV = 1 and no transfer occurs.
- Timing: let edge 0 be the first edge at which i_Rx_Serial = 0 is captured, and N = DATA_BITS + (PARITY_MODE ≠ 0) + STOP_BITS.
  - Last sample is at edge 3 + H + N·CLKS_PER_BIT.
  - o_Rx_DV is high after that edge. Example: CLKS_PER_BIT = 16, 8N1 gives edge 154.
- Widths: counter is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(max(DATA_BITS, 2)) bits; no overflow possible.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - PARITY_NONE/ODD/EVEN constants;
  - a function computing H.
- Sub-module sync_2ff: generic two-flop synchroniser with a reset value parameter (1 here). It is shared with future transmitter/flow-control blocks.

Test Plan:
- CLKS_PER_BIT = 16, 8N1, send 0xA5, i_Rx_Ready = 0 → o_Rx_DV high after edge 154, o_Rx_Byte = 0xA5, all flags 0, held until i_Rx_Ready = 1; falls the cycle after acceptance.
- DATA_BITS = 7, PARITY_MODE = 2, send 0x41 with parity 0 → byte 0x41, o_Parity_Err = 0; repeat with parity 1 → o_Parity_Err = 1, byte still 0x41.
- 8N1, stop bit forced 0 on 0x3C → o_Frame_Err = 1; line held low 30 bit times → one frame with o_Break = 1, byte 0x00, no further frames until the line returns high.
- Low glitch of 4 cycles on an idle line → no o_Rx_DV, state back to IDLE; then a valid 0x55 → received correctly.
- Two back-to-back frames 0x11, 0x22 with i_Rx_Ready = 0 → o_Overrun 1-cycle pulse at the second completion, o_Rx_Byte stays 0x11; repeat with i_Rx_Ready pulsed on the completion edge → 0x22 loaded, no overrun.
- STOP_BITS = 2, i_Reset pulsed during bit 3 of a frame → o_Rx_DV stays 0, outputs 0; next frame 0xF0 → received with no errors.
